// File: rtl/logic_unit_pkg.sv
// Shared op codes, FSM state encoding and helpers for the pipelined logic unit.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_XOR     = 3'd2;
  localparam logic [2:0] OP_NAND    = 3'd3;
  localparam logic [2:0] OP_NOR     = 3'd4;
  localparam logic [2:0] OP_XNOR    = 3'd5;
  localparam logic [2:0] OP_ACC_OR  = 3'd6;
  localparam logic [2:0] OP_ACC_XOR = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  function automatic logic is_acc_op(input logic [2:0] op);
    return (op == OP_ACC_OR) || (op == OP_ACC_XOR);
  endfunction

endpackage

// File: rtl/logic_unit_alu.sv
// Combinational bitwise a-op-b; the accumulate ops fold their beat with plain OR/XOR.
module logic_unit_alu
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  function automatic logic gate_bit(input logic x, input logic z, input logic [2:0] sel);
    logic r;
    case (sel)
      OP_AND:     r = x & z;
      OP_OR:      r = x | z;
      OP_XOR:     r = x ^ z;
      OP_NAND:    r = ~(x & z);
      OP_NOR:     r = ~(x | z);
      OP_XNOR:    r = ~(x ^ z);
      OP_ACC_OR:  r = x | z;
      OP_ACC_XOR: r = x ^ z;
      default:    r = x ^ z;
    endcase
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign y[gi] = gate_bit(a[gi], b[gi], op);
    end
  endgenerate

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit logic unit with valid/ready handshake and multi-beat OR/XOR accumulation.
// Optional out_parity port is enabled by defining LOGIC_UNIT_PARITY_EN.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_BEATS = 15,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
`ifdef LOGIC_UNIT_PARITY_EN
  output logic             err,
  output logic             out_parity
`else
  output logic             err
`endif
);

  state_t           state_reg;
  logic [2:0]       lock_op_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [CNT_W-1:0] out_count_reg;
  logic             err_reg;

  logic [WIDTH-1:0] ab_next;
  logic [WIDTH-1:0] fold_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             op_change;
  logic             continue_seq;
  logic             emit;
  logic [WIDTH-1:0] emit_data;
  logic [CNT_W-1:0] emit_count;

  logic_unit_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (in_a),
    .b  (in_b),
    .op (in_op),
    .y  (ab_next)
  );

  assign in_ready     = !out_valid_reg || out_ready;
  assign accept       = in_valid && in_ready;
  assign op_change    = (state_reg == ST_ACCUM) && (in_op != lock_op_reg);
  assign continue_seq = (state_reg == ST_ACCUM) && !op_change;
  assign fold_next    = (lock_op_reg == OP_ACC_OR) ? (acc_reg | ab_next) : (acc_reg ^ ab_next);
  // Count saturates so a long sequence never reports a wrapped beat count.
  assign cnt_inc      = (cnt_reg >= CNT_W'(MAX_BEATS)) ? CNT_W'(MAX_BEATS) : cnt_reg + CNT_W'(1);

  // An op change falls through to the idle handling, so only a continuing sequence folds.
  always_comb begin
    emit_data  = continue_seq ? fold_next : ab_next;
    emit_count = continue_seq ? cnt_inc : CNT_W'(1);
    if (continue_seq) begin
      emit = accept && in_last;
    end else begin
      emit = accept && !(is_acc_op(in_op) && !in_last);
    end
  end

`ifdef LOGIC_UNIT_PARITY_EN
  logic out_parity_reg;
  assign out_parity = out_parity_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      lock_op_reg   <= 3'd0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
      err_reg       <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
      out_parity_reg <= 1'b0;
`endif
    end else begin
      err_reg <= accept && op_change;

      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end

      if (emit) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= emit_data;
        out_count_reg <= emit_count;
`ifdef LOGIC_UNIT_PARITY_EN
        out_parity_reg <= ^emit_data;
`endif
      end

      if (accept) begin
        if (continue_seq && !in_last) begin
          acc_reg <= fold_next;
          cnt_reg <= cnt_inc;
        end else if (!continue_seq && is_acc_op(in_op) && !in_last) begin
          acc_reg     <= ab_next;
          cnt_reg     <= CNT_W'(1);
          lock_op_reg <= in_op;
          state_reg   <= ST_ACCUM;
        end else begin
          acc_reg   <= '0;
          cnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus random traffic against a sequence-level model.
module tb_logic_unit_pipe;

  localparam int W  = 16;
  localparam int MB = 15;
  localparam int CW = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [2:0]    in_op;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          err;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .err       (err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: pending output plus the list of folded beat values of the open sequence.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_count;
  bit           m_err;
  logic [W-1:0] seq_q[$];
  logic [2:0]   seq_op;

  function automatic logic [W-1:0] gate(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input logic last);
    logic [W-1:0] r;
    if (seq_q.size() > 0 && op != seq_op) begin
      m_err = 1'b1;
      seq_q.delete();
    end
    if (op < 3'd6) begin
      m_valid = 1'b1;
      m_data  = gate(a, b, op);
      m_count = 1;
    end else begin
      seq_q.push_back(gate(a, b, op));
      seq_op = op;
      if (last) begin
        r = '0;
        foreach (seq_q[k]) r = (op == 3'd6) ? (r | seq_q[k]) : (r ^ seq_q[k]);
        m_valid = 1'b1;
        m_data  = r;
        m_count = (seq_q.size() > MB) ? MB : seq_q.size();
        seq_q.delete();
      end
    end
  endtask

  task automatic cycle(output bit accepted);
    bit exp_rdy;
    bit drain;
    #1;
    exp_rdy = !m_valid || out_ready;
    chk("in_ready", in_ready, exp_rdy);
    accepted = in_valid && exp_rdy;
    drain    = m_valid && out_ready;
    @(posedge clk);
    #1;
    m_err = 1'b0;
    if (drain) m_valid = 1'b0;
    if (accepted) model_beat(in_a, in_b, in_op, in_last);
    chk("out_valid", out_valid, m_valid);
    chk("err", err, m_err);
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_count", out_count, m_count);
    end
    $display("t=%0t vld=%0b rdy=%0b op=%0d last=%0b acc=%0b | out_valid=%0b data=%h cnt=%0d err=%0b",
             $time, in_valid, out_ready, in_op, in_last, accepted, out_valid, out_data, out_count, err);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input logic last);
    bit acc;
    in_a = a; in_b = b; in_op = op; in_last = last; in_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) cycle(acc);
    if (!acc) begin
      n_assert++;
      n_fail++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted op=%0d", op);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int t = 0; t < n; t++) cycle(acc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    m_valid = 1'b0; m_err = 1'b0; seq_q.delete();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    $display("t=%0t reset done", $time);
  endtask

  initial begin
    logic [W-1:0] exp_ops [6];
    bit acc;
    exp_ops[0] = 16'hF000; exp_ops[1] = 16'hFFF0; exp_ops[2] = 16'h0FF0;
    exp_ops[3] = 16'h0FFF; exp_ops[4] = 16'h000F; exp_ops[5] = 16'hF00F;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 3'd0; in_last = 1'b0; out_ready = 1'b1;
    m_valid = 1'b0; m_data = '0; m_count = 0; m_err = 1'b0; seq_op = 3'd0;
    do_reset();

    // Ops 0-5 back to back.
    for (int op = 0; op < 6; op++) begin
      send(16'hF0F0, 16'hFF00, 3'(op), 1'b0);
      chk("op_result", out_data, exp_ops[op]);
      chk("op_count", out_count, 1);
    end
    idle(1);

    // Back-pressure: first result held while three beats wait.
    send(16'hF0F0, 16'hFF00, 3'd0, 1'b0);
    out_ready = 1'b0;
    in_a = 16'hF0F0; in_b = 16'hFF00; in_op = 3'd1; in_last = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      cycle(acc);
      chk("bp_hold_data", out_data, 16'hF000);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    send(16'hF0F0, 16'hFF00, 3'd1, 1'b0);
    chk("bp_beat1", out_data, 16'hFFF0);
    send(16'hF0F0, 16'hFF00, 3'd2, 1'b0);
    chk("bp_beat2", out_data, 16'h0FF0);
    send(16'hF0F0, 16'hFF00, 3'd3, 1'b0);
    chk("bp_beat3", out_data, 16'h0FFF);
    idle(2);

    // ACC_XOR of three beats.
    send(16'h0001, 16'h0002, 3'd7, 1'b0);
    send(16'h0004, 16'h0000, 3'd7, 1'b0);
    chk("accx_no_out", out_valid, 0);
    send(16'h0010, 16'h0020, 3'd7, 1'b1);
    chk("accx_data", out_data, 16'h0037);
    chk("accx_count", out_count, 3);
    idle(1);

    // ACC_OR of 20 beats saturates the count.
    for (int i = 0; i < 20; i++) send(16'(1 << (i % 16)), 16'h0000, 3'd6, i == 19);
    chk("accor_data", out_data, 16'hFFFF);
    chk("accor_count", out_count, 15);
    idle(1);

    // Op change mid-accumulation.
    send(16'h1234, 16'h0000, 3'd6, 1'b0);
    send(16'h00FF, 16'h0F0F, 3'd0, 1'b0);
    chk("chg_err", err, 1);
    chk("chg_data", out_data, 16'h000F);
    chk("chg_count", out_count, 1);
    idle(1);
    chk("chg_err_pulse", err, 0);

    // Reset with a pending result and a beat in flight.
    send(16'hAAAA, 16'h5555, 3'd1, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd2;
    do_reset();
    out_ready = 1'b1;
    idle(1);

    // Reset while accumulating discards the partial.
    send(16'hFF00, 16'h0000, 3'd7, 1'b0);
    do_reset();
    send(16'h0003, 16'h0005, 3'd7, 1'b1);
    chk("post_rst_data", out_data, 16'h0006);
    chk("post_rst_count", out_count, 1);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_op     = 3'($urandom_range(0, 7));
      in_last   = ($urandom_range(0, 3) == 0);
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      cycle(acc);
    end
    out_ready = 1'b1;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
